// File: rtl/pipe_pkg.sv
// Shared defaults and sizing helpers for the pipeline result receiver.
package pipe_pkg;

  localparam int PIPE_N     = 10;
  localparam int PIPE_DEPTH = 4;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pipe_rx_fifo.sv
// Synchronous result FIFO with an unreset register-array store and a combinational head read.
module pipe_rx_fifo
  import pipe_pkg::*;
#(
  parameter int N     = PIPE_N,
  parameter int DEPTH = PIPE_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [N-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [N-1:0]  o_rdata,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_drop
);

  localparam int PW = ptr_w(DEPTH);

  logic [N-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  // A pop on the same edge frees the slot, so a push at full still lands.
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_drop  = i_push && w_full && !w_pop;

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/pipe_result_rx.sv
// Pipeline result receiver: buffers results, hands them out over valid/ready,
// and grants issue credits so the buffer can never be overrun.
module pipe_result_rx
  import pipe_pkg::*;
#(
  parameter int N     = PIPE_N,
  parameter int DEPTH = PIPE_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          issue_ok,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          protocol_err
);

  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [CW-1:0] r_inflight;
  logic          r_overflow;
  logic          r_protocol_err;

  logic          w_empty;
  logic          w_drop;
  logic [CW:0]   w_committed;
  logic          w_iss_acc;
  logic          w_ret;

  pipe_rx_fifo #(.N(N), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (in_valid),
    .i_wdata (in_data),
    .i_pop   (out_ready),
    .o_rdata (out_data),
    .o_count (count),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  assign out_valid = !w_empty;

  // Evaluated one bit wider so buffered + in-flight can never wrap.
  assign w_committed = {1'b0, count} + {1'b0, r_inflight};
  assign issue_ok    = (w_committed < DEPTH_W);
  assign w_iss_acc   = issue && issue_ok;
  assign w_ret       = in_valid && (r_inflight != '0);

  assign overflow     = r_overflow;
  assign protocol_err = r_protocol_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight     <= '0;
      r_overflow     <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_iss_acc && !w_ret)      r_inflight <= r_inflight + CW'(1);
      else if (!w_iss_acc && w_ret) r_inflight <= r_inflight - CW'(1);
      if (w_drop) r_overflow <= 1'b1;
      if ((issue && !issue_ok) || (in_valid && r_inflight == '0))
        r_protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_result_rx.sv
// Scoreboard bench for pipe_result_rx: a 3-stage pipeline stand-in feeds results,
// a queue model predicts buffer contents, credits and sticky flags every cycle.
module tb_pipe_result_rx;

  localparam int N     = 10;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue;
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          issue_ok;
  logic          out_valid;
  logic [N-1:0]  out_data;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic          protocol_err;

  pipe_result_rx #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue        (issue),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .issue_ok     (issue_ok),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .count        (count),
    .overflow     (overflow),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  int           n_chk  = 0;
  int           n_pass = 0;
  logic [N-1:0] q[$];
  int           m_infl = 0;
  logic         m_ovf  = 1'b0;
  logic         m_perr = 1'b0;
  logic [2:0]   pv;
  logic [N-1:0] pd [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model.
  // frc injects d straight onto in_valid/in_data, bypassing the pipeline stand-in.
  task automatic cyc(input logic iss, input logic [N-1:0] d, input logic rdy, input logic frc);
    int sz;
    bit pop, iok, full, ret;
    sz = q.size();
    chk("count", 32'(count), 32'(sz));
    chk("out_valid", 32'(out_valid), 32'(sz != 0));
    chk("issue_ok", 32'(issue_ok), 32'((sz + m_infl) < DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("protocol_err", 32'(protocol_err), 32'(m_perr));
    if (sz != 0) chk("out_data", 32'(out_data), 32'(q[0]));

    issue     = iss;
    out_ready = rdy;
    in_valid  = pv[2] | frc;
    in_data   = frc ? d : pd[2];
    pv    = {pv[1:0], iss};
    pd[2] = pd[1];
    pd[1] = pd[0];
    pd[0] = d;

    if (!rst_n) begin
      q.delete();
      m_infl = 0;
      m_ovf  = 1'b0;
      m_perr = 1'b0;
    end else begin
      iok  = (sz + m_infl) < DEPTH;
      pop  = (sz != 0) && rdy;
      full = (sz == DEPTH);
      ret  = in_valid && (m_infl > 0);
      if (iss && !iok) m_perr = 1'b1;
      if (in_valid && m_infl == 0) m_perr = 1'b1;
      if (iss && iok) m_infl++;
      if (ret) m_infl--;
      if (pop) void'(q.pop_front());
      if (in_valid) begin
        if (full && !pop) m_ovf = 1'b1;
        else q.push_back(in_data);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pv    = '0;
    cyc(1'b0, '0, 1'b0, 1'b0);
    pv    = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; issue = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    pv = '0;
    for (int i = 0; i < 3; i++) pd[i] = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
    chk("rst_iok", 32'(issue_ok), 32'd1);
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_ovld", 32'(out_valid), 32'd0);

    // 2: ordering, then more rounds to wrap the pointers twice
    cyc(1'b1, 10'd60, 1'b1, 1'b0);
    cyc(1'b1, 10'd160, 1'b1, 1'b0);
    cyc(1'b1, 10'd84, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) cyc(1'b1, N'(r * 97 + k * 31 + 5), 1'b1, 1'b0);
      repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk("ord_empty", 32'(out_valid), 32'd0);

    // 3: back-pressure, upstream obeys issue_ok
    for (int k = 0; k < 4; k++) cyc(issue_ok, N'(200 + k), 1'b0, 1'b0);
    chk("bp_iok_low", 32'(issue_ok), 32'd0);
    repeat (4) cyc(issue_ok, '0, 1'b0, 1'b0);
    chk("bp_full", 32'(count), 32'd4);
    chk("bp_ovf", 32'(overflow), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("bp_iok_back", 32'(issue_ok), 32'd1);

    // refill to full
    cyc(1'b1, 10'd300, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, '0, 1'b0, 1'b0);
    chk("refill_cnt", 32'(count), 32'd4);

    // 4: push+pop at full, then a dropped push
    cyc(1'b0, 10'd777, 1'b1, 1'b1);
    chk("fpp_cnt", 32'(count), 32'd4);
    chk("fpp_ovf", 32'(overflow), 32'd0);
    cyc(1'b0, 10'd555, 1'b0, 1'b1);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("perr_set", 32'(protocol_err), 32'd1);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("perr_sticky", 32'(protocol_err), 32'd1);

    // 5: issue while not permitted
    do_reset();
    for (int k = 0; k < 4; k++) cyc(1'b1, N'(400 + k), 1'b0, 1'b0);
    repeat (4) cyc(1'b0, '0, 1'b0, 1'b0);
    chk("pe_pre", 32'(protocol_err), 32'd0);
    cyc(1'b1, 10'd999, 1'b0, 1'b0);
    chk("pe_set", 32'(protocol_err), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("pe_infl", 32'(issue_ok), 32'd1);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0);

    // 6: reset with count=2, inflight=2
    do_reset();
    cyc(1'b1, 10'd11, 1'b0, 1'b0);
    cyc(1'b1, 10'd22, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 10'd33, 1'b0, 1'b0);
    cyc(1'b1, 10'd44, 1'b0, 1'b0);
    chk("mid_cnt", 32'(count), 32'd2);
    chk("mid_iok", 32'(issue_ok), 32'd0);
    cyc(1'b1, '0, 1'b0, 1'b0);
    chk("mid_perr", 32'(protocol_err), 32'd1);
    do_reset();
    chk("mrst_cnt", 32'(count), 32'd0);
    chk("mrst_ovld", 32'(out_valid), 32'd0);
    chk("mrst_iok", 32'(issue_ok), 32'd1);
    chk("mrst_perr", 32'(protocol_err), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    repeat (5) cyc(1'b0, '0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_result_rx.md
Name: pipe_result_rx

Overview:
- Receiving end of the N-bit pipelined arithmetic datapath. It captures each result word the pipeline emits, tagged with a valid bit that travels alongside the operands, into a small FIFO.
- Results are handed downstream over a valid/ready handshake.
- Credit-based flow control: issue_ok tells the operand issuer when it may launch a new operand set, so no result can ever arrive to a full buffer.
- Sits between the pipeline output f and any stalling consumer.

Parameters:
- N, 10, data width of the pipeline result f.
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- CW, $clog2(DEPTH+1), width of the count and credit counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- issue  input  1  upstream launched one operand set into the pipeline this cycle.
- in_valid  input  1  pipeline output f carries a valid result this cycle.
- in_data  input  N  pipeline result f.
- issue_ok  output  1  upstream may assert issue this cycle.
- out_valid  output  1  out_data holds the oldest buffered result.
- out_data  output  N  head-of-FIFO result.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  CW  entries currently stored.
- overflow  output  1  sticky: a push was dropped because the FIFO was full.
- protocol_err  output  1  sticky: issue while !issue_ok, or in_valid with zero results in flight.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - wr_ptr, rd_ptr, count, inflight, overflow and protocol_err all go to 0.
  - out_valid=0 and issue_ok=1 from the following cycle.
  - FIFO memory contents are not reset.
  - Reset mid-operation discards all stored and in-flight results.
- Push: in_valid=1.
  - Write in_data to mem[wr_ptr]; wr_ptr wraps modulo DEPTH.
  - If count==DEPTH and no pop this cycle, the word is dropped and overflow is set.
- Pop: out_valid && out_ready.
  - rd_ptr increments, wrapping modulo DEPTH.
  - out_ready with out_valid=0 has no effect.
- Outputs:
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr], read combinationally from the register array.
  - out_data is undefined while out_valid=0.
- Simultaneous push and pop:
  - count is unchanged.
  - When full, the push is accepted because the pop frees the slot in the same edge.
  - When empty, no bypass occurs: the word appears on out_data the next cycle.
- Credit:
  - inflight counts issued operand sets whose result has not yet arrived.
  - issue_ok = (count + inflight) < DEPTH, combinational from registered state.
  - Accepted issue: issue && issue_ok increments inflight.
  - issue && !issue_ok is not counted and sets protocol_err.
  - in_valid decrements inflight if inflight>0; otherwise it sets protocol_err (data is still pushed if room).
  - Simultaneous accepted issue and in_valid leaves inflight unchanged.
- Latency:
  - Push to out_valid: 1 cycle.
  - Pop to issue_ok reassertion: 1 cycle.
- Invariant: count + inflight ≤ DEPTH whenever protocol_err=0.
- Arithmetic width: count+inflight is evaluated at CW+1 bits, so it cannot wrap.

Decomposition:
- Package pipe_pkg:
  - PIPE_N=10 and PIPE_DEPTH=4 defaults.
  - Function ptr_w(depth) = $clog2(depth).
- One sub-module, pipe_rx_fifo: a synchronous FIFO with the push/pop/count/full/empty behaviour above.
- Credit counter, issue_ok and sticky error flags stay in the top.

Test Plan:
1. Reset, then idle → out_valid=0, count=0, issue_ok=1, overflow=0, protocol_err=0.
2. Ordering and wrap:
   - Stimulus: 3 issues; results 10'd60, 10'd160, 10'd84 arrive 3 cycles later; out_ready=1.
   - Response: out_data is 60, 160, 84 in order, each one cycle after its push; inflight returns to 0.
   - Repeat until the pointers wrap twice; ordering is preserved.
3. Back-pressure:
   - Stimulus: out_ready=0, issue every cycle.
   - Response: issue_ok drops after the 4th issue; after 4 results, count=4 and overflow=0.
   - Then pulse out_ready for 1 cycle → issue_ok=1 the next cycle.
4. Full with simultaneous push and pop:
   - Stimulus: count=4, then in_valid=1 and out_ready=1 together.
   - Response: count stays 4, the new word is stored, overflow=0.
   - Force in_valid with inflight=0 at full and no pop → overflow=1 and protocol_err=1, both sticky until reset.
5. Protocol error: issue while issue_ok=0 → protocol_err=1 and inflight unchanged.
6. Reset mid-stream: rst_n=0 with count=2 and inflight=2 → the next cycle shows count=0, out_valid=0, issue_ok=1, and both flags cleared.
